// File: rtl/am2940_word_counter.sv
// Am2940 word-count section: loads a transfer length, counts transfers,
// raises a transfer-complete flag, and reads its count back onto the bus.
//
// Optional build macro: AM2940_DONE_LATCH_EN
//   defined   -> done is sticky until load, reinit or reset
//   undefined -> done reflects the most recent count event only
//
// The readback port is named do_data because "do" is a reserved word.
module am2940_word_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] di,
  input  logic         wr_n,
  input  logic         reinit_n,
  input  logic         cnte_n,
  input  logic [1:0]   mode,
  input  logic         rd_n,
  output logic [W-1:0] do_data,
  output logic         do_valid,
  output logic         done,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_wc;
  logic [W-1:0] r_cnt;
  logic         r_done;
  logic [W-1:0] r_do;
  logic         r_do_valid;

  logic [W-1:0] w_wc_nxt;
  logic [W-1:0] w_cnt_nxt;
  logic         w_done_nxt;
  logic         w_term;

  // Next-state selection with priority load > reinit > count.
  always_comb begin
    w_wc_nxt   = r_wc;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = r_done;
    w_term     = 1'b0;
    if (!wr_n) begin
      w_wc_nxt   = di;
      w_cnt_nxt  = (mode == 2'b01) ? '0 : di;
      w_done_nxt = 1'b0;
    end else if (!reinit_n) begin
      w_cnt_nxt  = (mode == 2'b01) ? '0 : r_wc;
      w_done_nxt = 1'b0;
    end else if (!cnte_n) begin
      case (mode)
        2'b00: begin
          w_cnt_nxt = r_cnt - ONE;
          w_term    = (w_cnt_nxt == '0);
`ifdef AM2940_DONE_LATCH_EN
          w_done_nxt = r_done | w_term;
`else
          w_done_nxt = w_term;
`endif
        end
        2'b01: begin
          w_cnt_nxt = r_cnt + ONE;
          w_term    = (w_cnt_nxt == r_wc);
`ifdef AM2940_DONE_LATCH_EN
          w_done_nxt = r_done | w_term;
`else
          w_done_nxt = w_term;
`endif
        end
        default: begin
          // hold modes: count events are ignored entirely
          w_cnt_nxt  = r_cnt;
          w_done_nxt = r_done;
        end
      endcase
    end
  end

  // Word-count register, counter and completion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wc   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_wc   <= w_wc_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Readback captures the pre-update count; data holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_do       <= '0;
      r_do_valid <= 1'b0;
    end else if (!rd_n) begin
      r_do       <= r_cnt;
      r_do_valid <= 1'b1;
    end else begin
      r_do_valid <= 1'b0;
    end
  end

  assign do_data  = r_do;
  assign do_valid = r_do_valid;
  assign done     = r_done;
  assign cnt_o    = r_cnt;

endmodule
